// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
package bcd_timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} timer_state_t;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Clamp a raw nibble into the legal BCD range 0..9.
  function automatic logic [3:0] sanitise_digit(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_digit.sv
// One BCD decade that counts 9..0 and raises a borrow when it wraps
// from 0 back to 9. Digits are chained through dec_in/borrow_out so a
// borrow ripples through every digit within a single clock.
import bcd_timer_pkg::*;

module bcd_down_digit (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [BCD_W-1:0] load_digit,
  input  logic             dec_in,
  output logic [BCD_W-1:0] digit,
  output logic             borrow_out
);

  logic [BCD_W-1:0] digit_q;
  logic [BCD_W-1:0] digit_d;

  // Next value: a load overrides any decrement; 0 wraps to 9.
  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_digit;
    end else if (dec_in) begin
      digit_d = (digit_q == '0) ? BCD_MAX : digit_q - 4'd1;
    end
  end

  // Digit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit      = digit_q;
  assign borrow_out = dec_in && (digit_q == '0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer with load, start, pause and a one-cycle
// done pulse when the count reaches zero.
// Optional feature macro: AUTO_RELOAD_EN -- when defined, the terminal tick
// reloads the last loaded value and keeps running (periodic timer).
//
// Handshake: there is no valid/ready flow control. load, start, pause and
// tick are sampled every rising edge with priority load > pause > start >
// tick; tick is a one-cycle strobe and only counts while the timer is in RUN.
import bcd_timer_pkg::*;

module bcd_countdown_timer #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  tick,
  output logic [4*DIGITS-1:0]   count,
  output logic                  zero,
  output logic                  busy,
  output logic                  done
);

  localparam int W = BCD_W * DIGITS;

  timer_state_t   state_q;
  logic           busy_q;
  logic           done_q;

  logic [W-1:0]   load_san;
  logic [W-1:0]   count_w;
  logic [DIGITS:0] dec_chain;
  logic           zero_w;
  logic           run_tick;
  logic           terminal;
  logic           digit_load;
  logic [W-1:0]   digit_src;
  logic           unused_borrow;

  // Out-of-range digits in the preset are clamped to 9.
  for (genvar k = 0; k < DIGITS; k++) begin : g_san
    assign load_san[k*BCD_W +: BCD_W] = sanitise_digit(load_val[k*BCD_W +: BCD_W]);
  end

  assign zero_w   = (count_w == '0);
  // A tick only counts in RUN and is dropped if pause or load wins this cycle.
  assign run_tick = (state_q == RUN) && tick && !pause && !load;
  assign terminal = run_tick && (count_w == W'(1));

`ifdef AUTO_RELOAD_EN
  logic [W-1:0] reload_q;
  logic         reload_fire;

  assign reload_fire = terminal && (reload_q != '0);
  assign digit_load  = load || reload_fire;
  assign digit_src   = load ? load_san : reload_q;

  // Remembers the last preset so a periodic run can restart from it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reload_q <= '0;
    end else if (load) begin
      reload_q <= load_san;
    end
  end
`else
  assign digit_load = load;
  assign digit_src  = load_san;
`endif

  // Decrement enters at digit 0; never decrement an already-zero count.
  assign dec_chain[0] = run_tick && !zero_w;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_down_digit u_digit (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (digit_load),
      .load_digit (digit_src[k*BCD_W +: BCD_W]),
      .dec_in     (dec_chain[k]),
      .digit      (count_w[k*BCD_W +: BCD_W]),
      .borrow_out (dec_chain[k+1])
    );
  end

  // A borrow out of the top digit cannot occur because zero is never decremented.
  assign unused_borrow = dec_chain[DIGITS];

  // Control FSM with registered busy and done outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE, PAUSE: begin
            if (!pause && start && !zero_w) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
          RUN: begin
            if (pause) begin
              state_q <= PAUSE;
              busy_q  <= 1'b0;
            end else if (terminal) begin
              done_q <= 1'b1;
`ifdef AUTO_RELOAD_EN
              if (reload_q == '0) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
              end
`else
              state_q <= DONE;
              busy_q  <= 1'b0;
`endif
            end
          end
          DONE: begin
            state_q <= DONE;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count = count_w;
  assign zero  = zero_w;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer (DIGITS=4): directed vector
// table, hand-written async-reset sequences, then randomized traffic
// checked against a decimal-integer reference model.
module tb_bcd_countdown_timer;

`ifdef AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_val = '0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        tick = 1'b0;
  logic [15:0] count;
  logic        zero;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  bcd_countdown_timer #(.DIGITS(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .pause    (pause),
    .tick     (tick),
    .count    (count),
    .zero     (zero),
    .busy     (busy),
    .done     (done)
  );

  int n_vec  = 0;
  int n_fail = 0;

  // ---------------- reference model (decimal integer) ----------------
  // m_st: 0 idle, 1 run, 2 pause, 3 done
  int m_val;
  int m_reload;
  int m_st;
  bit m_done;

  function automatic int san_val(input logic [15:0] raw);
    int v = 0;
    int p = 1;
    int d;
    for (int k = 0; k < 4; k++) begin
      d = int'(raw[k*4 +: 4]);
      if (d > 9) d = 9;
      v += d * p;
      p *= 10;
    end
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    int x = v;
    for (int k = 0; k < 4; k++) begin
      r[k*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_val = 0; m_reload = 0; m_st = 0; m_done = 1'b0;
  endtask

  task automatic model_step(input bit l, input logic [15:0] lv, input bit s, input bit p, input bit t);
    m_done = 1'b0;
    if (l) begin
      m_val = san_val(lv);
      m_reload = m_val;
      m_st = 0;
    end else if (m_st == 1) begin
      if (p) m_st = 2;
      else if (t) begin
        if (m_val == 1) begin
          m_done = 1'b1;
          if (AUTO && m_reload != 0) m_val = m_reload;
          else begin m_val = 0; m_st = 3; end
        end else begin
          m_val = m_val - 1;
        end
      end
    end else if ((m_st == 0 || m_st == 2) && !p && s && m_val != 0) begin
      m_st = 1;
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    exp_q.push_back(to_bcd(m_val));
    chk({tag, ".count"}, count, exp_q.pop_front());
    chk({tag, ".busy"}, 16'(busy), 16'(m_st == 1));
    chk({tag, ".done"}, 16'(done), 16'(m_done));
    chk({tag, ".zero"}, 16'(zero), 16'(m_val == 0));
  endtask

  // ---------------- driver ----------------
  task automatic apply(input bit l, input logic [15:0] lv, input bit s, input bit p, input bit t);
    load = l; load_val = lv; start = s; pause = p; tick = t;
    @(posedge clk);
    #1;
    model_step(l, lv, s, p, t);
    load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
  endtask

  task automatic async_reset_check(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk({tag, ".count"}, count, 16'h0000);
    chk({tag, ".busy"}, 16'(busy), 16'd0);
    chk({tag, ".done"}, 16'(done), 16'd0);
    chk({tag, ".zero"}, 16'(zero), 16'd1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          ld;
    logic [15:0] lv;
    bit          st;
    bit          pa;
    bit          tk;
    logic [15:0] ec;
    bit          eb;
    bit          ed;
    bit          ez;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mk(bit ld, logic [15:0] lv, bit st, bit pa, bit tk,
                              logic [15:0] ec, bit eb, bit ed, bit ez);
    vec_t v;
    v.ld = ld; v.lv = lv; v.st = st; v.pa = pa; v.tk = tk;
    v.ec = ec; v.eb = eb; v.ed = ed; v.ez = ez;
    return v;
  endfunction

  initial begin
    // countdown with borrow ripple 0100 -> 0099
    tab.push_back(mk(1, 16'h0105, 0, 0, 0, 16'h0105, 0, 0, 0));
    tab.push_back(mk(0, 16'h0000, 1, 0, 0, 16'h0105, 1, 0, 0));
    tab.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0104, 1, 0, 0));
    tab.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0103, 1, 0, 0));
    tab.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0102, 1, 0, 0));
    tab.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0101, 1, 0, 0));
    tab.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0100, 1, 0, 0));
    tab.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0099, 1, 0, 0));
    // full ripple through three digits
    tab.push_back(mk(1, 16'h1000, 0, 0, 0, 16'h1000, 0, 0, 0));
    tab.push_back(mk(0, 16'h0000, 1, 0, 1, 16'h1000, 1, 0, 0));
    tab.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0999, 1, 0, 0));
`ifndef AUTO_RELOAD_EN
    // terminal tick, done pulse, DONE is sticky
    tab.push_back(mk(1, 16'h0003, 0, 0, 0, 16'h0003, 0, 0, 0));
    tab.push_back(mk(0, 16'h0000, 1, 0, 0, 16'h0003, 1, 0, 0));
    tab.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0002, 1, 0, 0));
    tab.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0001, 1, 0, 0));
    tab.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0000, 0, 1, 1));
    tab.push_back(mk(0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 1));
    tab.push_back(mk(0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 1));
    tab.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0000, 0, 0, 1));
    tab.push_back(mk(0, 16'h0000, 1, 0, 1, 16'h0000, 0, 0, 1));
`else
    // periodic reload
    tab.push_back(mk(1, 16'h0002, 0, 0, 0, 16'h0002, 0, 0, 0));
    tab.push_back(mk(0, 16'h0000, 1, 0, 0, 16'h0002, 1, 0, 0));
    tab.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0001, 1, 0, 0));
    tab.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0002, 1, 1, 0));
    tab.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0001, 1, 0, 0));
    tab.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0002, 1, 1, 0));
`endif
    // pause + tick in the same cycle drops the tick
    tab.push_back(mk(1, 16'h0050, 0, 0, 0, 16'h0050, 0, 0, 0));
    tab.push_back(mk(0, 16'h0000, 1, 0, 0, 16'h0050, 1, 0, 0));
    tab.push_back(mk(0, 16'h0000, 0, 1, 1, 16'h0050, 0, 0, 0));
    tab.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0050, 0, 0, 0));
    tab.push_back(mk(0, 16'h0000, 1, 0, 0, 16'h0050, 1, 0, 0));
    tab.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h0049, 1, 0, 0));
    // sanitised load, load aborting a run
    tab.push_back(mk(1, 16'hF9A2, 0, 0, 0, 16'h9992, 0, 0, 0));
    tab.push_back(mk(0, 16'h0000, 1, 0, 0, 16'h9992, 1, 0, 0));
    tab.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h9991, 1, 0, 0));
    tab.push_back(mk(1, 16'h1234, 0, 0, 1, 16'h1234, 0, 0, 0));
    tab.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h1234, 0, 0, 0));
    tab.push_back(mk(0, 16'h0000, 0, 0, 1, 16'h1234, 0, 0, 0));
    // load wins over start; start at zero ignored; pause beats start
    tab.push_back(mk(1, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 1));
    tab.push_back(mk(0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 1));
    tab.push_back(mk(1, 16'h0007, 0, 0, 0, 16'h0007, 0, 0, 0));
    tab.push_back(mk(0, 16'h0000, 1, 1, 0, 16'h0007, 0, 0, 0));
    tab.push_back(mk(0, 16'h0000, 1, 0, 0, 16'h0007, 1, 0, 0));
  end

  // ---------------- main test ----------------
  initial begin
    model_reset();
    #3;
    chk("reset.count", count, 16'h0000);
    chk("reset.busy", 16'(busy), 16'd0);
    chk("reset.done", 16'(done), 16'd0);
    chk("reset.zero", 16'(zero), 16'd1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tab[i]) begin
      apply(tab[i].ld, tab[i].lv, tab[i].st, tab[i].pa, tab[i].tk);
      chk($sformatf("tab%0d.count", i), count, tab[i].ec);
      chk($sformatf("tab%0d.busy", i), 16'(busy), 16'(tab[i].eb));
      chk($sformatf("tab%0d.done", i), 16'(done), 16'(tab[i].ed));
      chk($sformatf("tab%0d.zero", i), 16'(zero), 16'(tab[i].ez));
    end

    // asynchronous reset in the middle of a run
    apply(1, 16'h0105, 0, 0, 0);
    apply(0, 16'h0000, 1, 0, 0);
    apply(0, 16'h0000, 0, 0, 1);
    chk("midrun.count", count, 16'h0104);
    async_reset_check("rst_midrun");

    // asynchronous reset while done is high clears it immediately
    apply(1, 16'h0001, 0, 0, 0);
    apply(0, 16'h0000, 1, 0, 0);
    apply(0, 16'h0000, 0, 0, 1);
    chk("pre_rst.done", 16'(done), 16'd1);
    async_reset_check("rst_done");

    // randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      bit          l, s, p, t;
      logic [15:0] lv;
      l  = ($urandom_range(0, 15) == 0);
      lv = ($urandom_range(0, 1) == 0) ? to_bcd($urandom_range(0, 20))
                                       : 16'($urandom_range(0, 65535));
      s  = ($urandom_range(0, 3) == 0);
      p  = ($urandom_range(0, 9) == 0);
      t  = ($urandom_range(0, 1) == 0);
      apply(l, lv, s, p, t);
      chk_model("rand");
      if ($urandom_range(0, 399) == 0) async_reset_check("rand_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
